dma_copy_engine: RTL and testbench

DMA_COPY_ENGINE -- requirements
Module: plab5_mcore_DMA_copy_engine

---
 rtl/dma_copy_engine.sv | 163 ++++++++++++++++
 tb/tb_dma_copy_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// Word-by-word memory-to-memory copy engine: one read then one write per word,
// with a single outstanding memory request and a one-cycle completion pulse.
module dma_copy_engine #(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_domain,
  input  logic [p_addr_nbits-1:0] req_src_addr,
  input  logic [p_addr_nbits-1:0] req_dest_addr,
  input  logic [7:0]              req_nwords,
  output logic                    resp_ack,
  output logic                    resp_domain,
  output logic [1:0]              resp_status,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic                    mem_req_type,
  output logic [p_addr_nbits-1:0] mem_req_addr,
  output logic [p_data_nbits-1:0] mem_req_data,
  input  logic                    mem_resp_val,
  input  logic [p_data_nbits-1:0] mem_resp_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RESP
  } state_t;

  localparam logic [1:0] STATUS_OK         = 2'b00;
  localparam logic [1:0] STATUS_MISALIGNED = 2'b01;
  localparam logic       MEM_READ          = 1'b0;
  localparam logic       MEM_WRITE         = 1'b1;
  localparam logic [p_addr_nbits-1:0] WORD_BYTES = p_addr_nbits'(4);

  state_t                  state;
  logic                    domain_q;
  logic [1:0]              status_q;
  logic [p_addr_nbits-1:0] src_addr;
  logic [p_addr_nbits-1:0] dest_addr;
  logic [7:0]              count;
  logic [p_data_nbits-1:0] data_buf;

  logic                    misaligned;
  logic [p_addr_nbits-1:0] src_next;
  logic [p_addr_nbits-1:0] dest_next;

  assign misaligned   = (req_src_addr[1:0] != 2'b00) || (req_dest_addr[1:0] != 2'b00);
  // Address increments wrap naturally at the top of the address space.
  assign src_next     = src_addr + WORD_BYTES;
  assign dest_next    = dest_addr + WORD_BYTES;
  assign mem_req_data = data_buf;

  // NOTE: every register here, including the data buffer, is cleared by reset so an
  // aborted copy leaves no stale command or data behind; all state updates are
  // non-blocking so each branch sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      domain_q     <= 1'b0;
      status_q     <= STATUS_OK;
      src_addr     <= '0;
      dest_addr    <= '0;
      count        <= '0;
      data_buf     <= '0;
      req_rdy      <= 1'b1;
      resp_ack     <= 1'b0;
      resp_domain  <= 1'b0;
      resp_status  <= STATUS_OK;
      mem_req_val  <= 1'b0;
      mem_req_type <= MEM_READ;
      mem_req_addr <= '0;
    end else begin
      resp_ack    <= 1'b0;
      resp_domain <= 1'b0;
      resp_status <= STATUS_OK;

      case (state)
        IDLE: begin
          if (req_val) begin
            domain_q  <= req_domain;
            status_q  <= misaligned ? STATUS_MISALIGNED : STATUS_OK;
            src_addr  <= req_src_addr;
            dest_addr <= req_dest_addr;
            count     <= req_nwords;
            req_rdy   <= 1'b0;
            if (misaligned || (req_nwords == 8'd0)) begin
              state       <= RESP;
              resp_ack    <= 1'b1;
              resp_domain <= req_domain;
              resp_status <= misaligned ? STATUS_MISALIGNED : STATUS_OK;
            end else begin
              state        <= RD_REQ;
              mem_req_val  <= 1'b1;
              mem_req_type <= MEM_READ;
              mem_req_addr <= req_src_addr;
            end
          end
        end

        RD_REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            state       <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_resp_val) begin
            data_buf     <= mem_resp_data;
            state        <= WR_REQ;
            mem_req_val  <= 1'b1;
            mem_req_type <= MEM_WRITE;
            mem_req_addr <= dest_addr;
          end
        end

        WR_REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            state       <= WR_WAIT;
          end
        end

        WR_WAIT: begin
          if (mem_resp_val) begin
            src_addr  <= src_next;
            dest_addr <= dest_next;
            count     <= count - 8'd1;
            if (count != 8'd1) begin
              state        <= RD_REQ;
              mem_req_val  <= 1'b1;
              mem_req_type <= MEM_READ;
              mem_req_addr <= src_next;
            end else begin
              state       <= RESP;
              resp_ack    <= 1'b1;
              resp_domain <= domain_q;
              resp_status <= status_q;
            end
          end
        end

        RESP: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: a cycle-stepped memory model checks every
// read/write against queued expectations and every ack against expected latency.
module tb_dma_copy_engine;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic        req_domain;
  logic [31:0] req_src_addr;
  logic [31:0] req_dest_addr;
  logic [7:0]  req_nwords;
  logic        resp_ack;
  logic        resp_domain;
  logic [1:0]  resp_status;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic        mem_req_type;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_resp_val;
  logic [31:0] mem_resp_data;

  dma_copy_engine #(
    .p_addr_nbits(32),
    .p_data_nbits(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_domain   (req_domain),
    .req_src_addr (req_src_addr),
    .req_dest_addr(req_dest_addr),
    .req_nwords   (req_nwords),
    .resp_ack     (resp_ack),
    .resp_domain  (resp_domain),
    .resp_status  (resp_status),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_type (mem_req_type),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_resp_val (mem_resp_val),
    .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dom;
    logic [1:0] st;
    int         lat;
    int         acc;
  } ack_exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle = 0;
  int          ack_cnt = 0;
  int          ack_base = 0;
  int          mem_val_cycles = 0;
  int          stall_rd = 0;
  bit          wr_fired = 0;
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];
  ack_exp_t    ack_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock step: advance past the edge, then act as memory and scoreboard.
  task automatic tick();
    logic        fire, prev_val, prev_rdy, ftype;
    logic [31:0] faddr, fdata;
    ack_exp_t    e;
    fire     = mem_req_val && mem_req_rdy;
    prev_val = mem_req_val;
    prev_rdy = mem_req_rdy;
    ftype    = mem_req_type;
    faddr    = mem_req_addr;
    fdata    = mem_req_data;
    @(posedge clk);
    #1;
    cycle++;

    if (prev_val && !prev_rdy) begin
      check("stall_val_held", 64'(mem_req_val), 64'd1);
      check("stall_type", 64'(mem_req_type), 64'(ftype));
      check("stall_addr_data", {mem_req_addr, mem_req_data}, {faddr, fdata});
    end

    mem_resp_val  = fire;
    mem_resp_data = '0;
    if (fire && !ftype) begin
      mem_resp_data = rd_data(faddr);
      if (rd_q.size() == 0) check("unexpected_read", 64'(faddr), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("read_addr", 64'(faddr), 64'(rd_q.pop_front()));
    end
    if (fire && ftype) begin
      wr_fired = 1;
      if (wr_q.size() == 0) check("unexpected_write", 64'(faddr), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("write_addr_data", {faddr, fdata}, wr_q.pop_front());
    end

    if (mem_req_val) begin
      mem_val_cycles++;
      check("req_rdy_busy", 64'(req_rdy), 64'd0);
    end
    if (mem_req_val && !mem_req_type && stall_rd > 0) begin
      mem_req_rdy = 1'b0;
      stall_rd--;
    end else begin
      mem_req_rdy = 1'b1;
    end

    if (resp_ack) begin
      ack_cnt++;
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 64'(resp_ack), 64'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_domain", 64'(resp_domain), 64'(e.dom));
        check("ack_status", 64'(resp_status), 64'(e.st));
        check("ack_latency", 64'(cycle - e.acc), 64'(e.lat));
      end
    end else begin
      check("idle_resp_fields", 64'({resp_domain, resp_status}), 64'd0);
    end
  endtask

  // Drive one command for a single cycle and queue everything it should produce.
  task automatic issue(input logic dom, input logic [31:0] src, input logic [31:0] dst,
                       input logic [7:0] n, input int stall);
    ack_exp_t e;
    logic     mis;
    check("req_rdy_idle", 64'(req_rdy), 64'd1);
    mis   = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    e.dom = dom;
    e.st  = mis ? 2'b01 : 2'b00;
    e.acc = cycle;
    e.lat = (mis || n == 8'd0) ? 1 : 1 + 4 * int'(n) + stall;
    ack_q.push_back(e);
    if (!mis) begin
      for (int i = 0; i < int'(n); i++) begin
        rd_q.push_back(src + 32'(4 * i));
        wr_q.push_back({dst + 32'(4 * i), rd_data(src + 32'(4 * i))});
      end
    end
    stall_rd       = stall;
    ack_base       = ack_cnt;
    mem_val_cycles = 0;
    req_val        = 1'b1;
    req_domain     = dom;
    req_src_addr   = src;
    req_dest_addr  = dst;
    req_nwords     = n;
    tick();
    req_val       = 1'b0;
    req_domain    = 1'b0;
    req_src_addr  = 32'hBAD0_0001;
    req_dest_addr = 32'hBAD0_0002;
    req_nwords    = 8'hEE;
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget && ack_cnt == ack_base; i++) tick();
    check("ack_arrived", 64'(ack_cnt - ack_base), 64'd1);
    tick();
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    req_val       = 1'b0;
    req_domain    = 1'b0;
    req_src_addr  = '0;
    req_dest_addr = '0;
    req_nwords    = '0;
    mem_req_rdy   = 1'b1;
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_rdy", 64'(req_rdy), 64'd1);
    check("rst_resp_ack", 64'(resp_ack), 64'd0);
    check("rst_resp_fields", 64'({resp_domain, resp_status}), 64'd0);
    check("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Three-word copy; a command held on req_val while busy must be ignored.
    issue(1'b1, 32'h0000_0100, 32'h0000_0200, 8'd3, 0);
    req_val      = 1'b1;
    req_nwords   = 8'd5;
    req_src_addr = 32'h0000_0700;
    for (int i = 0; i < 100 && ack_cnt == ack_base; i++) tick();
    req_val = 1'b0;
    wait_ack(5);

    // Zero-length copy: immediate ack, no memory traffic.
    issue(1'b0, 32'h0000_0010, 32'h0000_0020, 8'd0, 0);
    wait_ack(20);
    check("n0_no_mem_traffic", 64'(mem_val_cycles), 64'd0);

    // Misaligned source, then misaligned destination.
    issue(1'b1, 32'h0000_0102, 32'h0000_0200, 8'd4, 0);
    wait_ack(20);
    check("mis_src_no_mem_traffic", 64'(mem_val_cycles), 64'd0);
    issue(1'b0, 32'h0000_0100, 32'h0000_0203, 8'd2, 0);
    wait_ack(20);
    check("mis_dst_no_mem_traffic", 64'(mem_val_cycles), 64'd0);

    // Read request back-pressured for five cycles.
    issue(1'b1, 32'h0000_0040, 32'h0000_0080, 8'd1, 5);
    wait_ack(50);

    // Source address wraps past the top of memory.
    issue(1'b0, 32'hFFFF_FFFC, 32'h0000_0500, 8'd2, 0);
    wait_ack(50);

    // Reset while waiting on a write response, then a late response.
    issue(1'b1, 32'h0000_0300, 32'h0000_0400, 8'd2, 0);
    wr_fired = 0;
    for (int i = 0; i < 20 && !wr_fired; i++) tick();
    check("reached_wr_wait", 64'(wr_fired), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_req_rdy", 64'(req_rdy), 64'd1);
    check("abort_mem_req_val", 64'(mem_req_val), 64'd0);
    check("abort_resp_ack", 64'(resp_ack), 64'd0);
    ack_q.delete();
    rd_q.delete();
    wr_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_val  = 1'b1;
      mem_resp_data = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      cycle++;
      check("late_resp_no_ack", 64'(resp_ack), 64'd0);
      check("late_resp_req_rdy", 64'(req_rdy), 64'd1);
      check("late_resp_mem_idle", 64'(mem_req_val), 64'd0);
    end
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;

    // Normal operation after the abort, with a wrapping destination.
    issue(1'b1, 32'h0000_1000, 32'hFFFF_FFFC, 8'd2, 0);
    wait_ack(50);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
